// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter sharing one slow line-wide memory between
// an instruction cache (I) and a data cache (D). All outputs are registered.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SERV,
        DONE
    } state_t;

    state_t              state_q;
    // Last granted client (1 = D). Also identifies the client being served.
    logic                last_gnt_q;
    logic                last_gnt_d;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                i_ready_q;
    logic                d_ready_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic                i_pend;
    logic                d_pend;

    // Pending detection and round-robin choice of the client to grant next
    always_comb begin
        i_pend     = i_mem_read | i_mem_write;
        d_pend     = d_mem_read | d_mem_write;
        last_gnt_d = d_pend & (~i_pend | ~last_gnt_q);
    end

    // Arbitration FSM with registered memory-side and client-side outputs
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_pend || d_pend) begin
                        last_gnt_q <= last_gnt_d;
                        // Write wins when a client raises read and write together;
                        // the op is held in mem_read_q/mem_write_q for the whole SERV.
                        if (last_gnt_d) begin
                            mem_write_q <= d_mem_write;
                            mem_read_q  <= ~d_mem_write;
                            mem_addr_q  <= d_mem_addr;
                            mem_wdata_q <= d_mem_wdata;
                        end else begin
                            mem_write_q <= i_mem_write;
                            mem_read_q  <= ~i_mem_write;
                            mem_addr_q  <= i_mem_addr;
                            mem_wdata_q <= i_mem_wdata;
                        end
                        state_q <= SERV;
                    end
                end
                SERV: begin
                    if (mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (last_gnt_q) begin
                            d_ready_q <= 1'b1;
                            if (mem_read_q) d_rdata_q <= mem_rdata;
                        end else begin
                            i_ready_q <= 1'b1;
                            if (mem_read_q) i_rdata_q <= mem_rdata;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign i_mem_ready = i_ready_q;
    assign d_mem_ready = d_ready_q;
    assign i_mem_rdata = i_rdata_q;
    assign d_mem_rdata = d_rdata_q;

endmodule
